keypad_number_entry: RTL and testbench

- Multi-digit decimal entry stage between KeyboardDecoder and the game logic.
- Collects digit keypresses (main row and numeric keypad) into a BCD buffer, with backspace and clear.
- On Enter, converts the buffer to binary over several cycles, range-checks it, and emits the value with a one-cycle valid pulse.
- Successor to the single-digit key handler: configurable digit count, value width and range, plus editing keys.

---
 rtl/keypad_number_entry.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_number_entry.sv
// Multi-digit decimal keypad entry: BCD buffer with backspace/clear, serial BCD->binary on Enter.
// Optional inactivity clear of the buffer when ENTRY_TIMEOUT_EN is defined.
module keypad_number_entry #(
  parameter int MAX_DIGITS     = 2,
  parameter int VAL_W          = 7,
  parameter int MAX_VALUE      = 99,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [8:0]                         last_change,
  input  logic [511:0]                       key_down,
  output logic [4*MAX_DIGITS-1:0]            digits_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic [VAL_W-1:0]                   value,
  output logic                               value_valid,
  output logic                               err_pulse,
  output logic                               busy
);

  localparam int DW     = 4 * MAX_DIGITS;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W  = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int DEC_W  = $clog2(10 ** MAX_DIGITS);
  localparam int ACC_W  = (DEC_W > VAL_W) ? DEC_W : VAL_W;

  if (MAX_DIGITS < 1 || MAX_DIGITS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("keypad_number_entry: unsupported parameter set");
  end

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t             r_state, w_state_n;
  logic [DW-1:0]      r_digits, w_digits_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic [ACC_W-1:0]   r_acc, w_acc_n, w_acc_step;
  logic [IDX_W-1:0]   r_idx, w_idx_n;
  logic [VAL_W-1:0]   r_value, w_value_n;
  logic               r_vv, w_vv_n;
  logic               r_err, w_err_n;
  logic               r_held, w_held_n;
  logic [8:0]         r_held_code, w_held_code_n;

  logic               w_is_digit, w_is_bs, w_is_esc, w_is_enter;
  logic [3:0]         w_digit;
  logic               w_accept, w_release;
  logic [3:0]         w_sel;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0]    r_to, w_to_n;
`endif

  always_comb begin
    w_is_digit = 1'b1;
    w_is_bs    = 1'b0;
    w_is_esc   = 1'b0;
    w_is_enter = 1'b0;
    w_digit    = 4'd0;
    case (last_change)
      9'h045, 9'h070: w_digit = 4'd0;
      9'h016, 9'h069: w_digit = 4'd1;
      9'h01E, 9'h072: w_digit = 4'd2;
      9'h026, 9'h07A: w_digit = 4'd3;
      9'h025, 9'h06B: w_digit = 4'd4;
      9'h02E, 9'h073: w_digit = 4'd5;
      9'h036, 9'h074: w_digit = 4'd6;
      9'h03D, 9'h06C: w_digit = 4'd7;
      9'h03E, 9'h075: w_digit = 4'd8;
      9'h046, 9'h07D: w_digit = 4'd9;
      9'h066: begin w_is_digit = 1'b0; w_is_bs  = 1'b1; end
      9'h076: begin w_is_digit = 1'b0; w_is_esc = 1'b1; end
      9'h05A, 9'h15A: begin w_is_digit = 1'b0; w_is_enter = 1'b1; end
      default: w_is_digit = 1'b0;
    endcase
  end

  assign w_accept  = key_valid && key_down[last_change] && !r_held && (r_state == S_IDLE)
                     && (w_is_digit || w_is_bs || w_is_esc || w_is_enter);
  assign w_release = key_valid && !key_down[last_change] && r_held && (last_change == r_held_code);

  // Oldest digit first: idx walks from the most significant buffered nibble down to 0.
  assign w_sel      = r_digits[4*r_idx +: 4];
  assign w_acc_step = r_acc * ACC_W'(10) + ACC_W'(w_sel);

  always_comb begin
    w_state_n     = r_state;
    w_digits_n    = r_digits;
    w_count_n     = r_count;
    w_acc_n       = r_acc;
    w_idx_n       = r_idx;
    w_value_n     = r_value;
    w_vv_n        = 1'b0;
    w_err_n       = 1'b0;
    w_held_n      = r_held;
    w_held_code_n = r_held_code;
`ifdef ENTRY_TIMEOUT_EN
    w_to_n        = r_to;
`endif

    if (w_accept) begin
      w_held_n      = 1'b1;
      w_held_code_n = last_change;
    end else if (w_release) begin
      w_held_n = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ENTRY_TIMEOUT_EN
          w_to_n = '0;
`endif
          if (w_is_digit) begin
            if (r_count < CNT_W'(MAX_DIGITS)) begin
              w_digits_n = (r_digits << 4) | DW'(w_digit);
              w_count_n  = r_count + CNT_W'(1);
            end
          end else if (w_is_bs) begin
            if (r_count != '0) begin
              w_digits_n = r_digits >> 4;
              w_count_n  = r_count - CNT_W'(1);
            end
          end else if (w_is_esc) begin
            w_digits_n = '0;
            w_count_n  = '0;
          end else if (r_count == '0) begin
            w_err_n = 1'b1;
          end else begin
            w_state_n = S_CONV;
            w_acc_n   = '0;
            w_idx_n   = IDX_W'(r_count - CNT_W'(1));
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (r_count != '0) begin
          if (r_to == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_digits_n = '0;
            w_count_n  = '0;
            w_to_n     = '0;
          end else begin
            w_to_n = r_to + TO_W'(1);
          end
        end
`endif
      end
      S_CONV: begin
        w_acc_n = w_acc_step;
        w_idx_n = r_idx - IDX_W'(1);
        if (r_idx == '0) begin
          w_state_n  = S_IDLE;
          w_digits_n = '0;
          w_count_n  = '0;
          if (64'(w_acc_step) <= 64'(MAX_VALUE)) begin
            w_value_n = w_acc_step[VAL_W-1:0];
            w_vv_n    = 1'b1;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_digits    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_value     <= '0;
      r_vv        <= 1'b0;
      r_err       <= 1'b0;
      r_held      <= 1'b0;
      r_held_code <= '0;
`ifdef ENTRY_TIMEOUT_EN
      r_to        <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_digits    <= w_digits_n;
      r_count     <= w_count_n;
      r_acc       <= w_acc_n;
      r_idx       <= w_idx_n;
      r_value     <= w_value_n;
      r_vv        <= w_vv_n;
      r_err       <= w_err_n;
      r_held      <= w_held_n;
      r_held_code <= w_held_code_n;
`ifdef ENTRY_TIMEOUT_EN
      r_to        <= w_to_n;
`endif
    end
  end

  assign digits_bcd  = r_digits;
  assign digit_count = r_count;
  assign value       = r_value;
  assign value_valid = r_vv;
  assign err_pulse   = r_err;
  assign busy        = (r_state == S_CONV);

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry: default instance, a MAX_VALUE=25 instance and a short-timeout instance.
module tb_keypad_number_entry;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;

  logic [7:0] a_digits, b_digits, c_digits;
  logic [1:0] a_count, b_count, c_count;
  logic [6:0] a_value, b_value, c_value;
  logic       a_vv, b_vv, c_vv, a_err, b_err, c_err, a_busy, b_busy, c_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int a_vv_n = 0, a_err_n = 0, b_vv_n = 0, b_err_n = 0, c_vv_n = 0, c_err_n = 0;
  int snap_a_vv, snap_a_err, snap_c_vv, snap_c_err;

  always #5 clk = ~clk;

  keypad_number_entry #(.MAX_DIGITS(2), .VAL_W(7), .MAX_VALUE(99)) u_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change), .key_down(key_down),
    .digits_bcd(a_digits), .digit_count(a_count), .value(a_value),
    .value_valid(a_vv), .err_pulse(a_err), .busy(a_busy));

  keypad_number_entry #(.MAX_DIGITS(2), .VAL_W(7), .MAX_VALUE(25)) u_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change), .key_down(key_down),
    .digits_bcd(b_digits), .digit_count(b_count), .value(b_value),
    .value_valid(b_vv), .err_pulse(b_err), .busy(b_busy));

  keypad_number_entry #(.MAX_DIGITS(2), .VAL_W(7), .MAX_VALUE(99), .TIMEOUT_CYCLES(16)) u_c (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change), .key_down(key_down),
    .digits_bcd(c_digits), .digit_count(c_count), .value(c_value),
    .value_valid(c_vv), .err_pulse(c_err), .busy(c_busy));

  always @(posedge clk) begin
    if (a_vv)  a_vv_n++;
    if (a_err) a_err_n++;
    if (b_vv)  b_vv_n++;
    if (b_err) b_err_n++;
    if (c_vv)  c_vv_n++;
    if (c_err) c_err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [8:0] code);
    @(negedge clk);
    key_down[code] = 1'b1;
    last_change    = code;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic release_key(input logic [8:0] code);
    @(negedge clk);
    key_down[code] = 1'b0;
    last_change    = code;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic tap(input logic [8:0] code);
    press(code);
    release_key(code);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key_valid = 1'b0; last_change = '0; key_down = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_digits", a_digits, 0);
    chk("rst_count",  a_count,  0);
    chk("rst_value",  a_value,  0);
    chk("rst_vv",     a_vv,     0);
    chk("rst_err",    a_err,    0);
    chk("rst_busy",   a_busy,   0);

    // 1, 9, Enter -> 19, pulse N+1 = 3 cycles after accept
    press(9'h016);
    chk("t1_count1", a_count, 1);
    chk("t1_bcd1",   a_digits, 8'h01);
    release_key(9'h016);
    press(9'h046);
    chk("t1_count2", a_count, 2);
    chk("t1_bcd2",   a_digits, 8'h19);
    release_key(9'h046);
    press(9'h05A);
    chk("t1_busy_c1", a_busy, 1);
    chk("t1_vv_c1",   a_vv, 0);
    @(negedge clk);
    chk("t1_busy_c2", a_busy, 1);
    chk("t1_vv_c2",   a_vv, 0);
    @(negedge clk);
    chk("t1_vv_c3",    a_vv, 1);
    chk("t1_err_c3",   a_err, 0);
    chk("t1_busy_c3",  a_busy, 0);
    chk("t1_value",    a_value, 19);
    chk("t1_clr_cnt",  a_count, 0);
    chk("t1_clr_bcd",  a_digits, 0);
    chk("t1_b_value",  b_value, 19);
    release_key(9'h05A);
    chk("t1_vv_once", a_vv_n, 1);

    // keypad 7 held, 3 pressed meanwhile is ignored even after 7 released
    press(9'h06C);
    chk("t2_bcd7", a_digits, 8'h07);
    press(9'h026);
    chk("t2_cnt_ign", a_count, 1);
    release_key(9'h06C);
    release_key(9'h026);
    chk("t2_bcd_ign", a_digits, 8'h07);
    press(9'h15A);
    chk("t2_busy", a_busy, 1);
    @(negedge clk);
    chk("t2_vv",    a_vv, 1);
    chk("t2_value", a_value, 7);
    release_key(9'h15A);

    // 5, 5, Backspace, 2, Enter -> 52; B (max 25) rejects
    press(9'h02E);
    chk("t3_bcd05a", a_digits, 8'h05);
    release_key(9'h02E);
    press(9'h02E);
    chk("t3_bcd55", a_digits, 8'h55);
    release_key(9'h02E);
    press(9'h066);
    chk("t3_bcd05b", a_digits, 8'h05);
    chk("t3_cnt_bs", a_count, 1);
    release_key(9'h066);
    press(9'h01E);
    chk("t3_bcd52", a_digits, 8'h52);
    release_key(9'h01E);
    press(9'h05A);
    repeat (2) @(negedge clk);
    chk("t3_value",   a_value, 52);
    chk("t3_vv",      a_vv, 1);
    chk("t3_b_err",   b_err, 1);
    chk("t3_b_vv",    b_vv, 0);
    chk("t3_b_value", b_value, 7);
    chk("t3_b_count", b_count, 0);
    release_key(9'h05A);

    // 1, 2, 3 with two digits -> 3 ignored; then Escape; 4 then Escape
    tap(9'h016); tap(9'h01E); tap(9'h026);
    chk("t4_full_bcd", a_digits, 8'h12);
    chk("t4_full_cnt", a_count, 2);
    tap(9'h076);
    chk("t4_esc_cnt", a_count, 0);
    tap(9'h06B);
    chk("t4_bcd4", a_digits, 8'h04);
    tap(9'h076);
    chk("t4_esc4_cnt", a_count, 0);
    chk("t4_esc4_bcd", a_digits, 0);

    // 3, 0, Enter: 30 accepted by A, rejected by B (max 25)
    tap(9'h026); tap(9'h070);
    chk("t5_bcd30", a_digits, 8'h30);
    press(9'h05A);
    repeat (2) @(negedge clk);
    chk("t5_a_value", a_value, 30);
    chk("t5_b_err",   b_err, 1);
    chk("t5_b_value", b_value, 7);
    chk("t5_b_bcd",   b_digits, 0);
    release_key(9'h05A);

    // Enter on an empty buffer: error only, no conversion
    press(9'h05A);
    chk("t6_err",  a_err, 1);
    chk("t6_vv",   a_vv, 0);
    chk("t6_busy", a_busy, 0);
    @(negedge clk);
    chk("t6_err_1cyc", a_err, 0);
    release_key(9'h05A);
    repeat (2) @(negedge clk);
    chk("cnt_a_vv",  a_vv_n, 4);
    chk("cnt_a_err", a_err_n, 1);
    chk("cnt_b_vv",  b_vv_n, 2);
    chk("cnt_b_err", b_err_n, 3);

    // reset mid-conversion
    tap(9'h046); tap(9'h046);
    snap_a_vv = a_vv_n; snap_a_err = a_err_n;
    press(9'h05A);
    chk("t7_busy", a_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t7_busy_rst",  a_busy, 0);
    chk("t7_value_rst", a_value, 0);
    chk("t7_cnt_rst",   a_count, 0);
    chk("t7_bcd_rst",   a_digits, 0);
    @(negedge clk);
    rst = 1'b0;
    key_down = '0;
    repeat (5) @(negedge clk);
    chk("t7_no_vv",  a_vv_n, snap_a_vv);
    chk("t7_no_err", a_err_n, snap_a_err);
    chk("t7_value_hold", a_value, 0);

    // inactivity: instance C clears only when the timeout feature is built in
    snap_c_vv = c_vv_n; snap_c_err = c_err_n;
    press(9'h03E);
    release_key(9'h03E);
    repeat (6) @(negedge clk);
    chk("t8_c_cnt_early", c_count, 1);
    repeat (12) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
    chk("t8_c_cnt_late", c_count, 0);
    chk("t8_c_bcd_late", c_digits, 0);
`else
    chk("t8_c_cnt_late", c_count, 1);
    chk("t8_c_bcd_late", c_digits, 8'h08);
`endif
    chk("t8_a_persist", a_count, 1);
    chk("t8_c_no_vv",   c_vv_n, snap_c_vv);
    chk("t8_c_no_err",  c_err_n, snap_c_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
